// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the cpu control-word path: word width, y-bit indices,
// the instruction-start mask and the even-parity helper.
package cpu_ctrl_pkg;

    localparam int CW_W = 29;

    localparam int CW_Y1  = 0;  localparam int CW_Y2  = 1;  localparam int CW_Y3  = 2;
    localparam int CW_Y4  = 3;  localparam int CW_Y5  = 4;  localparam int CW_Y6  = 5;
    localparam int CW_Y7  = 6;  localparam int CW_Y8  = 7;  localparam int CW_Y9  = 8;
    localparam int CW_Y10 = 9;  localparam int CW_Y11 = 10; localparam int CW_Y12 = 11;
    localparam int CW_Y13 = 12; localparam int CW_Y14 = 13; localparam int CW_Y15 = 14;
    localparam int CW_Y16 = 15; localparam int CW_Y17 = 16; localparam int CW_Y18 = 17;
    localparam int CW_Y19 = 18; localparam int CW_Y20 = 19; localparam int CW_Y21 = 20;
    localparam int CW_Y22 = 21; localparam int CW_Y23 = 22; localparam int CW_Y24 = 23;
    localparam int CW_Y25 = 24; localparam int CW_Y26 = 25; localparam int CW_Y27 = 26;
    localparam int CW_Y28 = 27; localparam int CW_Y29 = 28;

    // y1 or y2 set marks the first micro-op of an instruction
    localparam logic [CW_W-1:0] CW_START_MASK =
        (CW_W'(1) << CW_Y1) | (CW_W'(1) << CW_Y2);

    function automatic logic cw_even_parity(input logic [CW_W-1:0] cw);
        return ^cw;
    endfunction

endpackage

// File: rtl/cpu_cw_fifo_mem.sv
// Unreset register array for the control-word queue: one synchronous write
// port and one asynchronous read port.
module cpu_cw_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 29
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Storage write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu_cw_issue_queue.sv
// Issue queue between the cpu control FSM and the datapath (valid/ready).
// Optional per-entry parity output enabled by defining CPU_CW_PARITY_EN.
module cpu_cw_issue_queue
    import cpu_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CW_W-1:0]            cw_in,
    input  logic                       flush,
    output logic [CW_W-1:0]            cw_out,
    output logic                       cw_vld,
    input  logic                       cw_rdy,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    output logic [CNT_W-1:0]           instr_cnt
`ifdef CPU_CW_PARITY_EN
    ,
    output logic                       cw_par
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
`ifdef CPU_CW_PARITY_EN
    localparam int MEM_W = CW_W + 1;
`else
    localparam int MEM_W = CW_W;
`endif

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             vld_q, vld_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic             push_req_s, pop_s, push_ok_s, we_s;
    logic [MEM_W-1:0] wr_data_s, rd_data_s;

    assign full  = (count_q == LVL_W'(DEPTH));
    assign empty = (count_q == LVL_W'(0));
    assign level = count_q;

    assign push_req_s = |cw_in;
    assign pop_s      = vld_q & cw_rdy;
    assign push_ok_s  = push_req_s & (~full | pop_s);
    assign we_s       = push_ok_s & ~flush;

`ifdef CPU_CW_PARITY_EN
    assign wr_data_s = {cw_even_parity(cw_in), cw_in};
    assign cw_par    = vld_q ? rd_data_s[CW_W] : 1'b0;
`else
    assign wr_data_s = cw_in;
`endif

    cpu_cw_fifo_mem #(.DEPTH(DEPTH), .W(MEM_W)) u_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_ptr_q),
        .wdata (wr_data_s),
        .raddr (rd_ptr_q),
        .rdata (rd_data_s)
    );

    // Head word is forced to zero whenever the queue is empty
    assign cw_out    = vld_q ? rd_data_s[CW_W-1:0] : CW_W'(0);
    assign cw_vld    = vld_q;
    assign ovf       = ovf_q;
    assign instr_cnt = icnt_q;

    // Next-state for pointers, occupancy, drop flag and instruction counter
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        icnt_d   = icnt_q;
        if (flush) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = LVL_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if ((cw_in & CW_START_MASK) != CW_W'(0)) begin
                    icnt_d = icnt_q + CNT_W'(1);
                end else begin
                    icnt_d = icnt_q;
                end
            end else begin
                ovf_d = ovf_q | push_req_s;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + LVL_W'(push_ok_s) - LVL_W'(pop_s);
        end
        vld_d = (count_d != LVL_W'(0));
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= LVL_W'(0);
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
            icnt_q   <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
            icnt_q   <= icnt_d;
        end
    end

endmodule
